// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 hex keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] COL_RST = 4'b1110;

    // Index of the single low bit in an active-low one-cold pattern.
    function automatic logic [1:0] low_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        case (v)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] keymap(input logic [1:0] c, input logic [1:0] r);
        logic [3:0] code;
        code = 4'h0;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'h0;
            4'hD: code = 4'hF;
            4'hE: code = 4'hE;
            4'hF: code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Generic two-flop synchronizer with asynchronous active-high reset.
module sync2 #(
    parameter int unsigned   W       = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with debounced press/release detection.
// Define KEYPAD_ENTRY_EN to build the 4-key entry shift register.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES   = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    input  logic        entry_clr,
    output logic [3:0]  col,
    output logic [3:0]  key,
    output logic        key_valid,
    output logic        pressed,
    output logic [15:0] entry
);

    localparam int unsigned MAX_CYC = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES
                                                                         : DEBOUNCE_CYCLES;
    localparam int unsigned CW = $clog2(MAX_CYC);
    localparam logic [CW-1:0] CNT_MAX     = CW'(MAX_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] DEB_LAST    = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    row_s;
    state_t        state, state_d;
    logic [3:0]    col_d;
    logic [CW-1:0] dwell, dwell_d;
    logic [CW-1:0] deb, deb_d;
    logic [3:0]    pat, pat_d;
    logic [3:0]    key_d;
    logic          key_valid_d;
    logic          pressed_d;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
        return (x == CNT_MAX) ? x : x + CW'(1);
    endfunction

    sync2 #(.W(4), .RST_VAL(4'b1111)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row),
        .q     (row_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SCAN;
            col       <= COL_RST;
            dwell     <= '0;
            deb       <= '0;
            pat       <= 4'b1111;
            key       <= 4'h0;
            key_valid <= 1'b0;
            pressed   <= 1'b0;
        end else begin
            state     <= state_d;
            col       <= col_d;
            dwell     <= dwell_d;
            deb       <= deb_d;
            pat       <= pat_d;
            key       <= key_d;
            key_valid <= key_valid_d;
            pressed   <= pressed_d;
        end
    end

    // Counters default to zero so every state change restarts them.
    always_comb begin
        state_d     = state;
        col_d       = col;
        dwell_d     = '0;
        deb_d       = '0;
        pat_d       = pat;
        key_d       = key;
        key_valid_d = 1'b0;
        case (state)
            SCAN: begin
                if (dwell == SETTLE_LAST) begin
                    if ($onehot(~row_s)) begin
                        state_d = DEBOUNCE;
                        pat_d   = row_s;
                    end else begin
                        col_d = {col[2:0], col[3]};
                    end
                end else begin
                    dwell_d = sat_inc(dwell);
                end
            end
            DEBOUNCE: begin
                if (row_s != pat) begin
                    state_d = SCAN;
                    col_d   = COL_RST;
                end else if (deb == DEB_LAST) begin
                    state_d     = PRESSED;
                    key_d       = keymap(low_idx(col), low_idx(pat));
                    key_valid_d = 1'b1;
                end else begin
                    deb_d = sat_inc(deb);
                end
            end
            PRESSED: begin
                if (row_s == 4'b1111) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (row_s != 4'b1111) begin
                    state_d = PRESSED;
                end else if (deb == DEB_LAST) begin
                    state_d = SCAN;
                    col_d   = {col[2:0], col[3]};
                end else begin
                    deb_d = sat_inc(deb);
                end
            end
            default: begin
                state_d = SCAN;
                col_d   = COL_RST;
            end
        endcase
        pressed_d = (state_d == PRESSED) || (state_d == RELEASE);
    end

`ifdef KEYPAD_ENTRY_EN
    // Clear has priority over a coincident key strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry <= 16'h0000;
        end else if (entry_clr) begin
            entry <= 16'h0000;
        end else if (key_valid) begin
            entry <= {entry[11:0], key};
        end
    end
`else
    logic unused_entry_clr;
    assign unused_entry_clr = entry_clr;
    assign entry            = 16'h0000;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a switch-matrix row model.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row;
    logic        entry_clr;
    logic [3:0]  col;
    logic [3:0]  key;
    logic        key_valid;
    logic        pressed;
    logic [15:0] entry;

    logic [15:0] kmask;
    logic [3:0]  sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          kv_cnt = 0;
    logic        prev_kv = 1'b0;

`ifdef KEYPAD_ENTRY_EN
    localparam bit ENTRY_ON = 1'b1;
`else
    localparam bit ENTRY_ON = 1'b0;
`endif

    keypad_scanner #(.SETTLE_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .entry_clr (entry_clr),
        .col       (col),
        .key       (key),
        .key_valid (key_valid),
        .pressed   (pressed),
        .entry     (entry)
    );

    always #5 clk = ~clk;

    // Closed switch at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (kmask[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (key_valid) begin
            kv_cnt++;
            check("kv_consec", 32'(prev_kv), 32'd0);
            check("kv_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) check("key_code", 32'(key), 32'(sb.pop_front()));
        end
        prev_kv = key_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pressed(input logic lvl, input int bound, input string tag);
        int i = 0;
        while (pressed !== lvl && i < bound) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(pressed), 32'(lvl));
    endtask

    task automatic wait_col_edge(input logic [3:0] tgt, input int bound, input string tag);
        int i = 0;
        while (col == tgt && i < bound) begin
            @(negedge clk);
            i++;
        end
        while (col != tgt && i < bound) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(col), 32'(tgt));
    endtask

    task automatic press_key(input int r, input int c, input logic [3:0] code);
        kmask = '0;
        kmask[r*4+c] = 1'b1;
        sb.push_back(code);
        wait_pressed(1'b1, 100, "press");
        tick(3);
        kmask = '0;
        wait_pressed(1'b0, 60, "release");
    endtask

    initial begin
        int  kv0;
        int  i;
        logic saw_adv;
        logic [3:0] ecol;

        reset = 1'b1;
        entry_clr = 1'b0;
        kmask = '0;
        tick(2);
        check("rst_col", 32'(col), 32'h0000000E);
        check("rst_key", 32'(key), 32'd0);
        check("rst_kv", 32'(key_valid), 32'd0);
        check("rst_pressed", 32'(pressed), 32'd0);
        check("rst_entry", 32'(entry), 32'd0);

        // Idle scan: each column held 4 cycles, wrapping back to col0.
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            ecol = ~(4'b0001 << ((k / 4) % 4));
            check("scan_col", 32'(col), 32'(ecol));
            tick(1);
        end

        // Key '5' at row1/col1.
        kv0 = kv_cnt;
        kmask = '0;
        kmask[1*4+1] = 1'b1;
        sb.push_back(4'h5);
        wait_pressed(1'b1, 100, "p5_press");
        for (int k = 0; k < 4; k++) begin
            check("p5_col_hold", 32'(col), 32'b1101);
            tick(1);
        end
        kmask = '0;
        wait_pressed(1'b0, 60, "p5_release");
        check("p5_col_next", 32'(col), 32'b1011);
        check("p5_key_hold", 32'(key), 32'h5);
        check("p5_kv_count", 32'(kv_cnt - kv0), 32'd1);

        // Bounce: key '2' drops out three cycles into debounce.
        kv0 = kv_cnt;
        wait_col_edge(4'b1101, 40, "b_sync");
        kmask = '0;
        kmask[0*4+1] = 1'b1;
        tick(4);
        tick(3);
        kmask = '0;
        saw_adv = 1'b0;
        i = 0;
        while (col != 4'b1110 && i < 12) begin
            if (col == 4'b1011) saw_adv = 1'b1;
            tick(1);
            i++;
        end
        check("b_restart", 32'(col), 32'b1110);
        check("b_no_adv", 32'(saw_adv), 32'd0);
        tick(3);
        check("b_dwell_c0", 32'(col), 32'b1110);
        tick(1);
        check("b_dwell_c1", 32'(col), 32'b1101);
        check("b_no_kv", 32'(kv_cnt - kv0), 32'd0);

        // Ghosting: two rows low in column 0 is rejected.
        kv0 = kv_cnt;
        wait_col_edge(4'b1110, 40, "g_sync");
        kmask = '0;
        kmask[0] = 1'b1;
        kmask[8] = 1'b1;
        tick(3);
        check("g_col0", 32'(col), 32'b1110);
        tick(1);
        check("g_adv", 32'(col), 32'b1101);
        kmask = '0;
        tick(20);
        check("g_no_kv", 32'(kv_cnt - kv0), 32'd0);

        // Release bounce on 'D' yields a single strobe.
        kv0 = kv_cnt;
        kmask = '0;
        kmask[15] = 1'b1;
        sb.push_back(4'hD);
        wait_pressed(1'b1, 100, "d_press");
        tick(5);
        kmask = '0;
        tick(3);
        kmask[15] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("d_hold", 32'(pressed), 32'd1);
            tick(1);
        end
        kmask = '0;
        wait_pressed(1'b0, 60, "d_release");
        check("d_kv_count", 32'(kv_cnt - kv0), 32'd1);

        // Asynchronous reset while a key is held.
        kmask[15] = 1'b1;
        sb.push_back(4'hD);
        wait_pressed(1'b1, 100, "r_press");
        tick(2);
        reset = 1'b1;
        #1;
        check("r_col", 32'(col), 32'b1110);
        check("r_pressed", 32'(pressed), 32'd0);
        check("r_key", 32'(key), 32'd0);
        check("r_kv", 32'(key_valid), 32'd0);
        kmask = '0;
        tick(2);
        reset = 1'b0;

        // Entry register: 1,2,3,4 then clear.
        press_key(0, 0, 4'h1);
        press_key(0, 1, 4'h2);
        press_key(0, 2, 4'h3);
        press_key(1, 0, 4'h4);
        check("entry_1234", 32'(entry), ENTRY_ON ? 32'h1234 : 32'h0);
        entry_clr = 1'b1;
        tick(1);
        entry_clr = 1'b0;
        check("entry_clr", 32'(entry), 32'h0);

        // Clear coinciding with a strobe of '7': clear wins, key updates.
        kmask = '0;
        kmask[2*4+0] = 1'b1;
        sb.push_back(4'h7);
        i = 0;
        while (!key_valid && i < 100) begin
            tick(1);
            i++;
        end
        check("cc_kv", 32'(key_valid), 32'd1);
        entry_clr = 1'b1;
        tick(1);
        entry_clr = 1'b0;
        check("cc_entry", 32'(entry), 32'h0);
        check("cc_key", 32'(key), 32'h7);
        kmask = '0;
        wait_pressed(1'b0, 60, "cc_release");
        press_key(2, 2, 4'h9);
        check("entry_9", 32'(entry), ENTRY_ON ? 32'h0009 : 32'h0);

        tick(5);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
